lfsr_arb: RTL and testbench

Random-priority arbiter that shares one downstream resource between NREQ requesters. A 4-bit LFSR with the team's standard tap arrangement picks the starting point of each round-robin search. The LFSR steps once per grant, so no requester is starved by fixed priority. It sits between request sources and a shared port, and grants are held until released.

---
 rtl/lfsr_arb.sv | 144 ++++++++++++++
 tb/tb_lfsr_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arb.sv
// lfsr_arb: random-priority arbiter for NREQ requesters sharing one port.
// A 4-bit LFSR (F,D,9,1,...) sets the start of a round-robin search. The
// LFSR steps once per issued grant. A grant is held until its request drops.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state
//   enable   0 blocks new grants (an active grant is unaffected)
//   req      request vector, one bit per requester
//   gnt      registered one-hot grant, or all zero
//   gnt_id   index of the current or last winner
//   busy     1 while a grant is active
//   timeout  one-cycle pulse on a forced release (0 unless LFSR_ARB_MAXHOLD_EN)
//   lfsr_q   current LFSR state
//
// Optional feature, macro LFSR_ARB_MAXHOLD_EN: limits a grant to MAX_HOLD
// cycles and then force-releases it with a timeout pulse.
module lfsr_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned PW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_id,
  output logic            busy,
  output logic            timeout,
  output logic [3:0]      lfsr_q
);

  if (!(NREQ == 2 || NREQ == 4 || NREQ == 8)) begin : g_bad_nreq
    $error("lfsr_arb: NREQ must be 2, 4 or 8");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("lfsr_arb: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gnt_id_q, gnt_id_d;
  logic [3:0]      lfsr_d;
  logic [PW-1:0]   ptr, idx, win_id;
  logic            win_found;

`ifdef LFSR_ARB_MAXHOLD_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  assign ptr = lfsr_q[PW-1:0];

  // First requester at or after ptr; NREQ is a power of two so the
  // PW-bit sum wraps modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr + PW'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    lfsr_d   = lfsr_q;
`ifdef LFSR_ARB_MAXHOLD_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          gnt_id_d       = win_id;
          lfsr_d         = {lfsr_q[2:1], lfsr_q[0] ^ lfsr_q[3], lfsr_q[3]};
`ifdef LFSR_ARB_MAXHOLD_EN
          hold_d         = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef LFSR_ARB_MAXHOLD_EN
        // hold_q counts completed grant cycles minus one at this edge
        end else if (hold_q == 8'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      lfsr_q   <= 4'hF;
`ifdef LFSR_ARB_MAXHOLD_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      lfsr_q   <= lfsr_d;
`ifdef LFSR_ARB_MAXHOLD_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == GRANT);
`ifdef LFSR_ARB_MAXHOLD_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_arb.sv
// Self-checking bench for lfsr_arb: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_lfsr_arb;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned PW       = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_id;
  logic            busy;
  logic            timeout;
  logic [3:0]      lfsr;

  lfsr_arb #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(rst), .enable(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout), .lfsr_q(lfsr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // LFSR sequence from reset, as a lookup table
  int seq[15] = '{15, 13, 9, 1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14};

  int m_owner;   // -1 when nobody holds the port
  int m_last;
  int m_si;      // position in seq
  int m_held;    // cycles the current owner has had gnt high
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_si    = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    int p;
    int j;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (en && req != '0) begin
        p = seq[m_si] % NREQ;
        for (int k = 0; k < NREQ; k++) begin
          j = (p + k) % NREQ;
          if (m_owner < 0 && req[j]) m_owner = j;
        end
        m_last = m_owner;
        m_si   = (m_si + 1) % 15;
        m_held = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_held++;
`ifdef LFSR_ARB_MAXHOLD_EN
      if (m_held == MAX_HOLD) begin
        m_owner = -1;
        m_to    = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all(input string tag);
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_id"}, 32'(gnt_id), 32'(m_last));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_lfsr"}, 32'(lfsr), 32'(seq[m_si]));
    chk({tag, "_to"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    chk({tag, "_rst_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rst_lfsr"}, 32'(lfsr), 32'hF);
    chk({tag, "_rst_id"}, 32'(gnt_id), 32'h0);
    chk({tag, "_rst_to"}, 32'(timeout), 32'h0);
    #2;
    rst = 1'b0;
  endtask

  int exp_w[6] = '{3, 1, 1, 1, 2, 0};

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("init");

    // all requesting: ptr 3 wins, then release
    en  = 1'b1;
    req = 4'b1111;
    step("t1a");
    chk("t1_gnt", 32'(gnt), 32'h8);
    chk("t1_lfsr", 32'(lfsr), 32'hD);
    req = 4'b0111;
    step("t1b");
    chk("t1_rel", 32'(gnt), 32'h0);

    // single low requester, search wraps, long hold
    do_reset("t2");
    req = 4'b0001;
    step("t2a");
    chk("t2_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 20; i++) step("t2h");
    chk("t2_hold_lfsr", 32'(lfsr), 32'hD);

    // back-to-back winners with immediate release
    do_reset("t3");
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      req = 4'b1111;
      step("t3g");
      chk("t3_winner", 32'(gnt_id), 32'(exp_w[i]));
      chk("t3_busy_hi", 32'(busy), 32'h1);
      req = 4'b1111 & ~(4'b0001 << exp_w[i]);
      step("t3r");
      chk("t3_busy_lo", 32'(busy), 32'h0);
    end

    // enable gating
    do_reset("t4");
    en  = 1'b0;
    req = 4'b0110;
    for (int i = 0; i < 3; i++) step("t4d");
    chk("t4_off_gnt", 32'(gnt), 32'h0);
    chk("t4_off_lfsr", 32'(lfsr), 32'hF);
    en = 1'b1;
    step("t4e");
    chk("t4_gnt", 32'(gnt), 32'h2);
    // enable low mid-grant keeps the grant
    en = 1'b0;
    step("t4k");
    chk("t4_keep", 32'(gnt), 32'h2);

    // reset in the middle of a grant
    do_reset("t5");
    en  = 1'b1;
    req = 4'b0010;
    step("t5a");
    do_reset("t5m");
    req = 4'b1111;
    step("t5b");
    chk("t5_winner", 32'(gnt_id), 32'h3);

`ifdef LFSR_ARB_MAXHOLD_EN
    do_reset("t6");
    req = 4'b0100;
    step("t6g");
    for (int i = 0; i < 15; i++) begin
      step("t6h");
      chk("t6_held", 32'(gnt), 32'h4);
    end
    step("t6t");
    chk("t6_to_gnt", 32'(gnt), 32'h0);
    chk("t6_to", 32'(timeout), 32'h1);
    step("t6r");
    chk("t6_regrant", 32'(gnt), 32'h4);
    chk("t6_to_clr", 32'(timeout), 32'h0);
`endif

    // random traffic
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      req = NREQ'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 149) == 0) do_reset("rndr");
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
